ifu_idu_fifo: RTL

- Parametrised IF→ID decoupling stage; replaces the single-entry IF/ID register with a DEPTH-entry (pc, instruction) queue.
- Full valid/ready handshake on both sides, plus a redirect flush that discards every queued entry.
- Lets the IFU keep fetching (icache hits) while the IDU stalls.
- Presents zero pc/instruction as a bubble when empty.
- Sits between IFU fetch output and IDU input.

---
 rtl/ifu_idu_fifo_pkg.sv | 10 +
 rtl/ifu_idu_fifo_if.sv | 21 ++
 rtl/ifu_idu_fifo_mem.sv | 18 +
 rtl/ifu_idu_fifo.sv | 58 +++++
 4 files changed

// File: rtl/ifu_idu_fifo_pkg.sv
// ifu_idu_fifo_pkg: shared entry-width helpers and the fixed low instruction bits for non-RVC builds
package ifu_idu_fifo_pkg;
    localparam logic [1:0] RVC_LOW = 2'b11;
    function automatic int ins_w(int xlen, int rvc);
        return (rvc != 0) ? xlen : xlen - 2;
    endfunction
    function automatic int entry_w(int xlen, int rvc);
        return xlen + ins_w(xlen, rvc);
    endfunction
endpackage

// File: rtl/ifu_idu_fifo_if.sv
// ifu_idu_fifo_if: IFU-side push and IDU-side pop handshakes of the IF/ID queue
interface ifu_idu_fifo_if #(parameter int XLEN = 32, parameter int DEPTH = 4);
    logic [XLEN-1:0]            i_pc;
    logic [XLEN-1:0]            i_ins;
    logic                       i_pre_valid;
    logic                       o_pre_ready;
    logic [XLEN-1:0]            o_pc;
    logic [XLEN-1:0]            o_ins;
    logic                       o_post_valid;
    logic                       i_post_ready;
    logic                       i_flush;
    logic [$clog2(DEPTH+1)-1:0] o_count;
    modport master (
        output i_pc, i_ins, i_pre_valid, i_post_ready, i_flush,
        input  o_pre_ready, o_pc, o_ins, o_post_valid, o_count
    );
    modport slave (
        input  i_pc, i_ins, i_pre_valid, i_post_ready, i_flush,
        output o_pre_ready, o_pc, o_ins, o_post_valid, o_count
    );
endinterface

// File: rtl/ifu_idu_fifo_mem.sv
// ifu_idu_fifo_mem: entry register array, one write port, asynchronous read
module ifu_idu_fifo_mem #(
    parameter int W     = 62,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem_q [DEPTH];
    always_ff @(posedge clock) begin
        if (we) mem_q[waddr] <= wdata;
    end
    assign rdata = mem_q[raddr];
endmodule

// File: rtl/ifu_idu_fifo.sv
// ifu_idu_fifo: DEPTH-entry (pc, instruction) queue decoupling IFU fetch from IDU decode
module ifu_idu_fifo
    import ifu_idu_fifo_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int RVC   = 0
) (
    input logic          clock,
    input logic          reset,
    ifu_idu_fifo_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int IW    = ins_w(XLEN, RVC);
    localparam int EW    = entry_w(XLEN, RVC);
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [EW-1:0]    rd_entry;
    logic [IW-1:0]    rd_ins;
    logic             empty, push, pop, unused_lo;
    assign empty            = count_q == '0;
    assign bus.o_pre_ready  = count_q != CNT_W'(DEPTH);
    assign bus.o_post_valid = !empty && !bus.i_flush;
    assign bus.o_count      = count_q;
    // a flush swallows any push offered in the same cycle
    assign push = bus.i_pre_valid && bus.o_pre_ready && !bus.i_flush;
    assign pop  = bus.o_post_valid && bus.i_post_ready;
    always_comb begin
        count_d = bus.i_flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
        wr_d    = bus.i_flush ? '0 : wr_q + PTR_W'(push);
        rd_d    = bus.i_flush ? '0 : rd_q + PTR_W'(pop);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end
    ifu_idu_fifo_mem #(.W(EW), .DEPTH(DEPTH)) u_mem (
        .clock (clock),
        .we    (push),
        .waddr (wr_q),
        .wdata ({bus.i_pc, bus.i_ins[XLEN-1 -: IW]}),
        .raddr (rd_q),
        .rdata (rd_entry)
    );
    assign unused_lo = ^bus.i_ins[1:0];
    assign rd_ins    = rd_entry[IW-1:0];
    assign bus.o_pc  = empty ? '0 : rd_entry[EW-1 -: XLEN];
    // without RVC every instruction is 32-bit, so the low bits are implied
    assign bus.o_ins = empty ? '0 : (RVC != 0 ? XLEN'(rd_ins) : {rd_ins[XLEN-3:0], RVC_LOW});
endmodule
